instr_fetch_stage: RTL
======================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage between the program counter and decode. Issues instruction reads to the
//  icache at the current PC, waits on ihit, captures the word into the IF/ID register,
//  and pulses pc_en so the PC advances exactly once per accepted instruction. A one-entry
//  skid buffer absorbs a hit that lands while decode stalls. Also handles flush and HALT.
// PARAMETERS
//  WORD_W       32             data/address width
//  HALT_OPCODE  32'hFFFFFFFF   instruction word that halts fetch
// PORTS
//  CLK        in   1       clock, rising edge
//  nRST       in   1       asynchronous active-low reset
//  pc         in   WORD_W  current PC from program_counter
//  pc_en      out  1       comb pulse: PC may advance this cycle
//  imemREN    out  1       icache read enable
//  imemaddr   out  WORD_W  icache address
//  ihit       in   1       icache hit; imemload valid this cycle
//  imemload   in   WORD_W  instruction word from icache
//  stall      in   1       decode cannot accept; hold IF/ID
//  flush      in   1       redirect (branch/jump taken); squash fetched work
//  instr_out  out  WORD_W  IF/ID instruction
//  pc_out     out  WORD_W  IF/ID PC of instr_out
//  npc_out    out  WORD_W  IF/ID PC+4
//  valid_out  out  1       IF/ID holds a live instruction
//  halt       out  1       HALT fetched; fetch stopped
// BEHAVIOUR
//  - States: FETCH, HOLD, HALTED. Reset (nRST low, async): state=FETCH; instr_out, pc_out,
//    npc_out, skid=0; valid_out=0; halt=0. pc_en=0 while nRST low.
//  - imemREN = (state==FETCH) & ~flush; imemaddr = {pc[31:2],2'b00} (low bits forced 0).
//  - consume = valid_out & ~stall. accept = state==FETCH & ihit & ~flush.
//  - FETCH, accept, (consume | ~valid_out): IF/ID <= {imemload, pc, pc+4}, valid_out<=1,
//    pc_en=1 same cycle. Zero latency from ihit to pc_en; IF/ID valid next cycle.
//  - FETCH, accept, valid_out & stall: skid <= {imemload, pc, pc+4}, pc_en=1, ->HOLD.
//  - FETCH, no accept, consume: valid_out<=0. No accept, no consume: IF/ID holds.
//  - HOLD: imemREN=0, pc_en=0; ignore ihit. When ~stall: IF/ID <= skid, valid_out stays 1,
//    ->FETCH. While stall: hold everything.
//  - Captured word == HALT_OPCODE (into IF/ID or skid): ->HALTED after HOLD drains if
//    needed; halt=1, imemREN=0, pc_en=0 until flush or reset. HALT is passed to decode
//    as a normal valid instruction.
//  - flush (highest priority, any state): valid_out<=0, skid cleared, halt<=0, ->FETCH;
//    pc_en=0 and imemload ignored that cycle even if ihit=1.
//  - flush and stall together: flush wins.
//  - npc_out = pc+4 modulo 2^WORD_W (0xFFFFFFFC -> 0x00000000, no error).
//  - At most one pc_en pulse per ihit; never pc_en in HOLD/HALTED or while nRST low.
// TESTING
//  1. pc=0x0, ihit=1 every cycle, stall=0, imemload=0x20010005 -> pc_en=1 each cycle;
//     next cycle instr_out=0x20010005, pc_out=0x0, npc_out=0x4, valid_out=1.
//  2. valid_out=1 & stall=1, ihit with 0x8C220000 -> pc_en=1 once, HOLD, imemREN=0;
//     stall drops -> instr_out=0x8C220000 next cycle, back to FETCH, no word lost/duplicated.
//  3. flush=1 same cycle as ihit (imemload=0x1234) -> pc_en=0, valid_out=0 next cycle,
//     0x1234 never appears on instr_out; flush in HOLD -> skid dropped.
//  4. imemload=0xFFFFFFFF accepted -> instr_out=0xFFFFFFFF valid, halt=1, imemREN=0,
//     pc_en stays 0 for 10 cycles with ihit=1; flush -> halt=0, imemREN=1.
//  5. pc=0xFFFFFFFC accepted -> npc_out=0x00000000; pc=0x00000006 -> imemaddr=0x00000004.
//  6. nRST low mid-HOLD with valid_out=1 -> immediately valid_out=0, halt=0, pc_en=0;
//     after release state FETCH, imemREN=1.

Source files
------------

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_stage
// Brief   : Icache fetch into the IF/ID register with a one-entry skid buffer,
//           flush redirect and HALT detection.
// Revision: 1.0  initial release
// ============================================================================
module instr_fetch_stage #(
  parameter int unsigned     WORD_W      = 32,
  parameter logic [WORD_W-1:0] HALT_OPCODE = 32'hFFFFFFFF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] pc,
  output logic              pc_en,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              stall,
  input  logic              flush,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] npc_out,
  output logic              valid_out,
  output logic              halt
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_npc;
  logic              r_valid;
  logic [WORD_W-1:0] r_skid_instr;
  logic [WORD_W-1:0] r_skid_pc;
  logic [WORD_W-1:0] r_skid_npc;
  logic              w_consume;
  logic              w_accept;
  logic [WORD_W-1:0] w_pc_plus4;

  assign w_consume  = r_valid & ~stall;
  assign w_accept   = (r_state == S_FETCH) & ihit & ~flush;
  assign w_pc_plus4 = pc + WORD_W'(4);

  assign imemaddr  = {pc[WORD_W-1:2], 2'b00};
  assign imemREN   = (r_state == S_FETCH) & ~flush;
  // Every accepted hit advances the PC, whether it lands in IF/ID or the skid.
  assign pc_en     = w_accept & nRST;
  assign instr_out = r_instr;
  assign pc_out    = r_pc;
  assign npc_out   = r_npc;
  assign valid_out = r_valid;
  assign halt      = (r_state == S_HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_accept) begin
          if (r_valid && stall) begin
            w_next_state = S_HOLD;
          end else if (imemload == HALT_OPCODE) begin
            w_next_state = S_HALTED;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_next_state = (r_skid_instr == HALT_OPCODE) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_FETCH;
    endcase
    if (flush) begin
      w_next_state = S_FETCH;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr      <= '0;
      r_pc         <= '0;
      r_npc        <= '0;
      r_valid      <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_npc   <= '0;
    end else if (flush) begin
      r_valid      <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_npc   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_accept) begin
            if (r_valid && stall) begin
              r_skid_instr <= imemload;
              r_skid_pc    <= pc;
              r_skid_npc   <= w_pc_plus4;
            end else begin
              r_instr <= imemload;
              r_pc    <= pc;
              r_npc   <= w_pc_plus4;
              r_valid <= 1'b1;
            end
          end else if (w_consume) begin
            r_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_instr <= r_skid_instr;
            r_pc    <= r_skid_pc;
            r_npc   <= r_skid_npc;
            r_valid <= 1'b1;
          end
        end
        S_HALTED: begin
          if (w_consume) begin
            r_valid <= 1'b0;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
